// File: rtl/alvio_write_ctrl_pkg.sv
// Shared types and sizing for the active-list violation RAM write controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro used by this slice: ALVIO_COALESCE_EN (report coalescing).
package alvio_write_ctrl_pkg;

    localparam int ALVIO_INDEX  = 4;                      // active-list ID width
    localparam int ALVIO_WIDTH  = 1;                      // violation word width
    localparam int ALVIO_QDEPTH = 4;                      // report queue entries
    localparam int ALVIO_QIDX   = $clog2(ALVIO_QDEPTH);   // queue pointer width

    // One violation report / one queue entry.
    typedef struct packed {
        logic                   valid;
        logic [ALVIO_INDEX-1:0] alId;
        logic [ALVIO_WIDTH-1:0] data;
    } al_vio_rpt_t;

endpackage

// File: rtl/alvio_write_ctrl_rpt_queue.sv
// 2-in/1-out circular report queue feeding the violation RAM write port.
// Latency: an entry written in cycle N is presented at the head in cycle N+1 at the earliest.
// Backpressure: none internally; the caller only presents enq0/enq1 when count leaves room for two.
// Ports: clk/reset, flush (clear all), enq0/enq1 (valid = accepted this cycle),
//        probe_id/probe_hit (any valid entry holds this ID), count, addr/data/we (head entry).
// With ALVIO_COALESCE_EN defined, reports matching a live entry OR into it instead of allocating.
module alvio_write_ctrl_rpt_queue
    import alvio_write_ctrl_pkg::*;
#(
    parameter int QDEPTH = ALVIO_QDEPTH,
    parameter int QIDX   = ALVIO_QIDX
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  al_vio_rpt_t            enq0,
    input  al_vio_rpt_t            enq1,
    input  logic [ALVIO_INDEX-1:0] probe_id,
    output logic                   probe_hit,
    output logic [QIDX:0]          count,
    output logic [ALVIO_INDEX-1:0] addr,
    output logic [ALVIO_WIDTH-1:0] data,
    output logic                   we
);

    localparam int CW = QIDX + 1;

    al_vio_rpt_t     mem_q [QDEPTH];
    al_vio_rpt_t     mem_d [QDEPTH];
    logic [QIDX-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            deq;
    logic            hit0, hit1, same;
    logic [QIDX-1:0] hit0_idx, hit1_idx;
    logic            alloc0, alloc1;
    logic [QIDX-1:0] slot0, slot1;

    // The write port is driven purely from registered state.
    assign deq   = (count_q != '0);
    assign we    = deq;
    assign addr  = mem_q[head_q].alId;
    assign data  = mem_q[head_q].data;
    assign count = count_q;

    always_comb begin
        probe_hit = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (mem_q[i].valid && (mem_q[i].alId == probe_id)) begin
                probe_hit = 1'b1;
            end
        end
    end

    // Coalesce match. The head entry leaving this cycle is not a merge target,
    // otherwise the OR'd bits would be lost with the outgoing write.
    always_comb begin
        hit0     = 1'b0;
        hit1     = 1'b0;
        same     = 1'b0;
        hit0_idx = '0;
        hit1_idx = '0;
`ifdef ALVIO_COALESCE_EN
        for (int i = 0; i < QDEPTH; i++) begin
            if (mem_q[i].valid && !(deq && (head_q == QIDX'(i)))) begin
                if (!hit0 && enq0.valid && (mem_q[i].alId == enq0.alId)) begin
                    hit0     = 1'b1;
                    hit0_idx = QIDX'(i);
                end
                if (!hit1 && enq1.valid && (mem_q[i].alId == enq1.alId)) begin
                    hit1     = 1'b1;
                    hit1_idx = QIDX'(i);
                end
            end
        end
        same = enq0.valid && enq1.valid && (enq0.alId == enq1.alId);
`endif
    end

    always_comb begin
        alloc0 = enq0.valid && !hit0;
        alloc1 = enq1.valid && !hit1 && !same;
        slot0  = hit0 ? hit0_idx : tail_q;
        slot1  = tail_q + QIDX'(alloc0);   // port 0 takes the tail slot first

        for (int i = 0; i < QDEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (deq) begin
            mem_d[head_q].valid = 1'b0;
        end
        if (enq0.valid) begin
            if (hit0) begin
                mem_d[slot0].data = mem_d[slot0].data | enq0.data;
            end else begin
                mem_d[slot0] = enq0;
            end
        end
        if (enq1.valid) begin
            if (same) begin
                mem_d[slot0].data = mem_d[slot0].data | enq1.data;
            end else if (hit1) begin
                mem_d[hit1_idx].data = mem_d[hit1_idx].data | enq1.data;
            end else begin
                mem_d[slot1] = enq1;
            end
        end

        head_d  = head_q + QIDX'(deq);
        tail_d  = tail_q + QIDX'(alloc0) + QIDX'(alloc1);
        count_d = count_q + CW'(alloc0) + CW'(alloc1) - CW'(deq);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // The accept gate upstream must keep the queue from ever filling completely.
    assert property (@(posedge clk) disable iff (reset) count_q != CW'(QDEPTH));

endmodule

// File: rtl/alvio_write_ctrl.sv
// Buffers up to two LSU violation reports per cycle and drains them one per cycle into the violation RAM.
// Latency: report accepted in cycle N is written at cycle N+1 at the earliest; no input-to-write-port path.
// Backpressure: ready_o drops when fewer than two entries are free; reports with ready_o low are dropped and set overflow_o.
// Ports: viol0/viol1 report inputs, flush_i, commitHead_i -> ready_o, headPending_o, overflow_o,
//        addr0wr_o/data0wr_o/we0_o RAM write port.
// Optional macro: ALVIO_COALESCE_EN (merge reports for an already-queued active-list ID).
module alvio_write_ctrl
    import alvio_write_ctrl_pkg::*;
#(
    parameter int INDEX  = ALVIO_INDEX,
    parameter int WIDTH  = ALVIO_WIDTH,
    parameter int QDEPTH = ALVIO_QDEPTH,
    parameter int QIDX   = ALVIO_QIDX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             viol0Valid_i,
    input  logic [INDEX-1:0] viol0AlId_i,
    input  logic [WIDTH-1:0] viol0Data_i,
    input  logic             viol1Valid_i,
    input  logic [INDEX-1:0] viol1AlId_i,
    input  logic [WIDTH-1:0] viol1Data_i,
    input  logic             flush_i,
    input  logic [INDEX-1:0] commitHead_i,
    output logic             ready_o,
    output logic             headPending_o,
    output logic [INDEX-1:0] addr0wr_o,
    output logic [WIDTH-1:0] data0wr_o,
    output logic             we0_o,
    output logic             overflow_o
);

    logic [QIDX:0] count;
    logic          acc0, acc1;
    logic          probe_hit;
    logic          overflow_q;
    al_vio_rpt_t   enq0, enq1;

    // Judged on registered count only, so a same-cycle dequeue never widens the window.
    assign ready_o = (count <= (QIDX+1)'(QDEPTH - 2));

    // A flush drops same-cycle reports silently; they are not an LSU contract violation.
    assign acc0 = viol0Valid_i && ready_o && !flush_i;
    assign acc1 = viol1Valid_i && ready_o && !flush_i;

    assign enq0 = {acc0, viol0AlId_i, viol0Data_i};
    assign enq1 = {acc1, viol1AlId_i, viol1Data_i};

    alvio_write_ctrl_rpt_queue #(
        .QDEPTH (QDEPTH),
        .QIDX   (QIDX)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_i),
        .enq0      (enq0),
        .enq1      (enq1),
        .probe_id  (commitHead_i),
        .probe_hit (probe_hit),
        .count     (count),
        .addr      (addr0wr_o),
        .data      (data0wr_o),
        .we        (we0_o)
    );

    // Commit must stall while the head ID's violation bit is queued or arriving.
    assign headPending_o = !flush_i &&
                           (probe_hit ||
                            (acc0 && (viol0AlId_i == commitHead_i)) ||
                            (acc1 && (viol1AlId_i == commitHead_i)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if ((viol0Valid_i || viol1Valid_i) && !ready_o && !flush_i) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_alvio_write_ctrl.sv
module tb_alvio_write_ctrl;

    localparam int INDEX = 4;
    localparam int WIDTH = 1;
    typedef logic [INDEX+WIDTH-1:0] wr_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             v0, v1, flush;
    logic [INDEX-1:0] id0, id1, chead;
    logic [WIDTH-1:0] d0, d1;
    logic             ready, hp, we, ovf;
    logic [INDEX-1:0] addr;
    logic [WIDTH-1:0] data;

    wr_t exp_q[$];
    wr_t got_q[$];
    int  n_pass  = 0;
    int  n_total = 0;

    always #5 clk = ~clk;

    alvio_write_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .viol0Valid_i  (v0),
        .viol0AlId_i   (id0),
        .viol0Data_i   (d0),
        .viol1Valid_i  (v1),
        .viol1AlId_i   (id1),
        .viol1Data_i   (d1),
        .flush_i       (flush),
        .commitHead_i  (chead),
        .ready_o       (ready),
        .headPending_o (hp),
        .addr0wr_o     (addr),
        .data0wr_o     (data),
        .we0_o         (we),
        .overflow_o    (ovf)
    );

    // Write-port monitor: records every RAM write, sampled mid-cycle.
    always @(negedge clk) begin
        if (we === 1'b1) got_q.push_back({addr, data});
    end

    task automatic idle();
        v0 = 1'b0; v1 = 1'b0; flush = 1'b0;
    endtask

    task automatic send(input logic [INDEX-1:0] a, input logic [WIDTH-1:0] da,
                        input logic b_en, input logic [INDEX-1:0] b, input logic [WIDTH-1:0] db);
        v0 = 1'b1; id0 = a; d0 = da;
        v1 = b_en; id1 = b; d1 = db;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        #12;
        n_total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else n_pass++;
        n_total++; if (we !== 1'b0) $display("FAIL reset_we: got %b expected 0", we); else n_pass++;
        n_total++; if (addr !== 4'd0) $display("FAIL reset_addr: got %h expected 0", addr); else n_pass++;
        n_total++; if (data !== 1'b0) $display("FAIL reset_data: got %h expected 0", data); else n_pass++;
        n_total++; if (hp !== 1'b0) $display("FAIL reset_headpending: got %b expected 0", hp); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", ovf); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        got_q.delete();
    endtask

    task automatic test_single();
        wr_t e, g;
        send(4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_q.push_back({4'd5, 1'b1});
        #1;
        n_total++; if (we !== 1'b0) $display("FAIL single_c1_we: got %b expected 0", we); else n_pass++;
        @(negedge clk);
        idle();
        n_total++; if (we !== 1'b1) $display("FAIL single_c2_we: got %b expected 1", we); else n_pass++;
        n_total++; if (addr !== 4'd5) $display("FAIL single_c2_addr: got %0d expected 5", addr); else n_pass++;
        n_total++; if (data !== 1'b1) $display("FAIL single_c2_data: got %0d expected 1", data); else n_pass++;
        @(negedge clk);
        n_total++; if (we !== 1'b0) $display("FAIL single_c3_we: got %b expected 0", we); else n_pass++;
        repeat (4) @(negedge clk);
        n_total++;
        if (got_q.size() != exp_q.size()) $display("FAIL single_writes: got %0d expected %0d", got_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_total++; if (g !== e) $display("FAIL single_order: got %h expected %h", g, e); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_dual();
        wr_t e, g;
        send(4'd3, 1'b1, 1'b1, 4'd9, 1'b1);
        exp_q.push_back({4'd3, 1'b1});
        exp_q.push_back({4'd9, 1'b1});
        @(negedge clk);
        idle();
        n_total++; if (ready !== 1'b1) $display("FAIL dual_ready: got %b expected 1", ready); else n_pass++;
        n_total++; if (addr !== 4'd3 || we !== 1'b1) $display("FAIL dual_first: got we %b addr %0d expected we 1 addr 3", we, addr); else n_pass++;
        @(negedge clk);
        n_total++; if (addr !== 4'd9 || we !== 1'b1) $display("FAIL dual_second: got we %b addr %0d expected we 1 addr 9", we, addr); else n_pass++;
        repeat (4) @(negedge clk);
        n_total++;
        if (got_q.size() != exp_q.size()) $display("FAIL dual_writes: got %0d expected %0d", got_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_total++; if (g !== e) $display("FAIL dual_order: got %h expected %h", g, e); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back();
        wr_t e, g;
        int mcnt = 0;
        int sent = 0;
        int acc;
        logic [INDEX-1:0] nid;
        for (int c = 0; c < 8; c++) begin
            n_total++;
            if (ready !== (mcnt <= 2)) $display("FAIL b2b_ready_c%0d: got %b expected %b", c, ready, (mcnt <= 2));
            else n_pass++;
            if (ready === 1'b1 && sent < 3) begin
                nid = INDEX'(2 * sent + 1);
                send(nid, nid[0], 1'b1, nid + 4'd1, ~nid[0]);
                exp_q.push_back({nid, nid[0]});
                exp_q.push_back({nid + 4'd1, ~nid[0]});
                sent++;
                acc = 2;
            end else begin
                idle();
                acc = 0;
            end
            n_total++; if (ovf !== 1'b0) $display("FAIL b2b_overflow_c%0d: got %b expected 0", c, ovf); else n_pass++;
            @(negedge clk);
            mcnt = mcnt + acc - ((mcnt > 0) ? 1 : 0);
        end
        idle();
        repeat (4) @(negedge clk);
        n_total++;
        if (got_q.size() != exp_q.size()) $display("FAIL b2b_writes: got %0d expected %0d", got_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_total++; if (g !== e) $display("FAIL b2b_order: got %h expected %h", g, e); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_flush();
        wr_t e, g;
        send(4'd10, 1'b1, 1'b1, 4'd11, 1'b0);
        exp_q.push_back({4'd10, 1'b1});
        exp_q.push_back({4'd11, 1'b0});
        @(negedge clk);
        send(4'd12, 1'b1, 1'b1, 4'd13, 1'b0);        // queued, then flushed
        @(negedge clk);
        send(4'd14, 1'b1, 1'b0, 4'd0, 1'b0);          // arrives with the flush
        flush = 1'b1;
        chead = 4'd12;
        #1;
        n_total++; if (hp !== 1'b0) $display("FAIL flush_hp_during: got %b expected 0", hp); else n_pass++;
        n_total++; if (we !== 1'b1 || addr !== 4'd11) $display("FAIL flush_same_cycle_write: got we %b addr %0d expected we 1 addr 11", we, addr); else n_pass++;
        @(negedge clk);
        send(4'd15, 1'b1, 1'b0, 4'd0, 1'b0);
        exp_q.push_back({4'd15, 1'b1});
        #1;
        n_total++; if (we !== 1'b0) $display("FAIL flush_we_after: got %b expected 0", we); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL flush_overflow: got %b expected 0", ovf); else n_pass++;
        n_total++; if (hp !== 1'b0) $display("FAIL flush_hp_after: got %b expected 0", hp); else n_pass++;
        n_total++; if (ready !== 1'b1) $display("FAIL flush_ready_after: got %b expected 1", ready); else n_pass++;
        @(negedge clk);
        idle();
        n_total++; if (we !== 1'b1 || addr !== 4'd15) $display("FAIL flush_restart: got we %b addr %0d expected we 1 addr 15", we, addr); else n_pass++;
        chead = 4'd0;
        repeat (4) @(negedge clk);
        n_total++;
        if (got_q.size() != exp_q.size()) $display("FAIL flush_writes: got %0d expected %0d", got_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_total++; if (g !== e) $display("FAIL flush_order: got %h expected %h", g, e); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_head_pending();
        wr_t e, g;
        logic [4:0] hp_exp;
        hp_exp = 5'b01110;
        chead  = 4'd7;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
                send(4'd2, 1'b0, 1'b1, 4'd6, 1'b1);
                exp_q.push_back({4'd2, 1'b0});
                exp_q.push_back({4'd6, 1'b1});
            end else if (c == 1) begin
                send(4'd7, 1'b1, 1'b0, 4'd0, 1'b0);
                exp_q.push_back({4'd7, 1'b1});
            end else begin
                idle();
            end
            #1;
            n_total++; if (hp !== hp_exp[c]) $display("FAIL headpending_c%0d: got %b expected %b", c, hp, hp_exp[c]); else n_pass++;
            @(negedge clk);
        end
        chead = 4'd0;
        repeat (3) @(negedge clk);
        n_total++;
        if (got_q.size() != exp_q.size()) $display("FAIL headpending_writes: got %0d expected %0d", got_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_total++; if (g !== e) $display("FAIL headpending_order: got %h expected %h", g, e); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_coalesce();
        wr_t e, g;
        send(4'd4, 1'b1, 1'b1, 4'd4, 1'b0);
`ifdef ALVIO_COALESCE_EN
        exp_q.push_back({4'd4, 1'b1});
`else
        exp_q.push_back({4'd4, 1'b1});
        exp_q.push_back({4'd4, 1'b0});
`endif
        @(negedge clk);
        idle();
        repeat (5) @(negedge clk);
        n_total++;
        if (got_q.size() != exp_q.size()) $display("FAIL coalesce_writes: got %0d expected %0d", got_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_total++; if (g !== e) $display("FAIL coalesce_order: got %h expected %h", g, e); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_overflow();
        wr_t e, g;
        send(4'd1, 1'b1, 1'b1, 4'd2, 1'b0);
        exp_q.push_back({4'd1, 1'b1});
        exp_q.push_back({4'd2, 1'b0});
        @(negedge clk);
        send(4'd3, 1'b1, 1'b1, 4'd8, 1'b0);
        exp_q.push_back({4'd3, 1'b1});
        exp_q.push_back({4'd8, 1'b0});
        @(negedge clk);
        idle();
        #1;
        n_total++; if (ready !== 1'b0) $display("FAIL ovf_ready_low: got %b expected 0", ready); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL ovf_before: got %b expected 0", ovf); else n_pass++;
        send(4'd5, 1'b1, 1'b0, 4'd0, 1'b0);          // illegal: ready is low, must be dropped
        @(negedge clk);
        idle();
        n_total++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %b expected 1", ovf); else n_pass++;
        repeat (5) @(negedge clk);
        n_total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", ovf); else n_pass++;
        n_total++;
        if (got_q.size() != exp_q.size()) $display("FAIL ovf_writes: got %0d expected %0d", got_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_total++; if (g !== e) $display("FAIL ovf_order: got %h expected %h", g, e); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        v0 = 1'b0; v1 = 1'b0; flush = 1'b0;
        id0 = '0; id1 = '0; d0 = '0; d1 = '0; chead = '0;
        test_reset();
        test_single();
        test_dual();
        test_back_to_back();
        test_flush();
        test_head_pending();
        test_coalesce();
        test_overflow();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alvio_write_ctrl.md
Name: alvio_write_ctrl

Overview:
Write-side controller for the active-list violation RAM. The LSU can report up to two load/store ordering violations per cycle, each tagged with an active-list ID. This block buffers those reports in a small circular queue and drains them one per cycle onto the RAM's single write port (addr/data/we). It also tells commit when a violation for the current head ID is still in flight, so commit stalls instead of reading a stale RAM entry.

Parameters:
INDEX, 4, width of active-list ID (RAM address width)
WIDTH, 1, width of violation word written to RAM
QDEPTH, 4, report queue entries (power of two, >= 2)
QIDX, 2, log2(QDEPTH)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
viol0Valid_i  in  1  violation report, port 0
viol0AlId_i  in  INDEX  active-list ID, port 0
viol0Data_i  in  WIDTH  violation word, port 0
viol1Valid_i  in  1  violation report, port 1
viol1AlId_i  in  INDEX  active-list ID, port 1
viol1Data_i  in  WIDTH  violation word, port 1
flush_i  in  1  recovery/exception flush; discard all pending reports
commitHead_i  in  INDEX  active-list ID at the commit head
ready_o  out  1  queue can accept two reports this cycle
headPending_o  out  1  a report for commitHead_i is queued or arriving
addr0wr_o  out  INDEX  RAM write address
data0wr_o  out  WIDTH  RAM write data
we0_o  out  1  RAM write enable
overflow_o  out  1  sticky error: a report arrived while ready_o was low

Behaviour:
- Reset (async, active-high): head, tail and count = 0; all entries invalid. Outputs: ready_o=1, we0_o=0, addr0wr_o=0, data0wr_o=0, headPending_o=0, overflow_o=0.
- Queue state: entry array {alId, data}, head and tail pointers (QIDX bits, wrap modulo QDEPTH), count (QIDX+1 bits).
- Write port: addr0wr_o, data0wr_o and we0_o depend only on queue registers. we0_o = (count != 0). Address and data come from the head entry.
- Dequeue: head advances every cycle where we0_o=1.
- Latency: a report accepted in cycle N appears on the write port in cycle N+1 at the earliest. There is no input-to-write-port combinational path.
- ready_o = (count <= QDEPTH-2). It is computed from registered count, ignoring any same-cycle dequeue.
- Enqueue: only when ready_o=1. Port 0 is written before port 1. With both valid, two entries are allocated (tail, tail+1).
- Count update: next count = count + enq - deq. Simultaneous enqueue and dequeue is legal. At count = QDEPTH-2 with two enqueues and one dequeue, next count = QDEPTH-1.
- Reports arriving with ready_o=0 are dropped and set overflow_o, which stays set until reset. The LSU contract forbids this.
- Flush: when flush_i=1, next cycle count=0, head=tail=0 and we0_o=0. Same-cycle reports are dropped without setting overflow. The same-cycle write (we0_o already high) still happens.
- headPending_o (combinational): high if any valid queued entry has alId==commitHead_i, or an accepted input port this cycle has alId==commitHead_i. Forced low when flush_i=1.
- Full/empty: count==0 means we0_o=0. count==QDEPTH is unreachable because ready_o guards it; an assertion checks this in simulation.

Optional Feature:
ALVIO_COALESCE_EN
- Defined: an accepted report whose alId matches a valid queued entry (excluding the head entry when it is dequeued this cycle) ORs its data into that entry and allocates nothing. If ports 0 and 1 carry the same alId in one cycle, they produce one entry with data0|data1. ready_o is unchanged (conservative).
- Undefined: every accepted report allocates its own entry. Duplicate IDs produce repeated RAM writes.

Decomposition:
- Shared package: al_vio_rpt_t struct {valid, alId[INDEX], data[WIDTH]}, plus constants ALVIO_QDEPTH/ALVIO_QIDX derived from the core config.
- Natural sub-module: alvio_rpt_queue, the 2-in/1-out circular FIFO holding pointers, count and the coalesce match.
- The top level adds the flush, headPending_o and overflow logic.

Test Plan:
- Reset, then port0 report {alId=5, data=1} in cycle 1 -> cycle 2: we0_o=1, addr0wr_o=5, data0wr_o=1; cycle 3: we0_o=0.
- Both ports in one cycle, {3,1} and {9,1} -> writes addr 3 then addr 9 in consecutive cycles; ready_o stays 1.
- Two-per-cycle reports for 3 cycles with QDEPTH=4 -> ready_o falls once count reaches 3. Holding reports while ready_o=0 keeps overflow_o=0; all reports are eventually written, in order.
- Queue holds 3 entries, flush_i pulsed together with a new report -> next cycle we0_o=0, count=0, overflow_o=0, headPending_o=0.
- commitHead_i=7 with a report for ID 7 arriving -> headPending_o=1 that cycle, and stays 1 until the cycle in which the entry is written.
- With ALVIO_COALESCE_EN defined, ports 0/1 both alId=4 (data 1 and 0) -> single write to addr 4 with data 1. Undefined -> two writes to addr 4.
